// File: rtl/tdm_mux_8ch_if.sv
// Bundle of the eight valid/ready input channels and the single muxed output stream of tdm_mux_8ch.
// master drives the channel inputs and out_ready. slave is the multiplexer side.
interface tdm_mux_8ch_if #(
  parameter int DATA_W = 8
);
  logic [8*DATA_W-1:0] in_data;
  logic [7:0]          in_valid;
  logic [7:0]          in_ready;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_sel;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/tdm_mux_8ch.sv
// 8-to-1 TDM multiplexer: round-robin grant into a one-entry output register tagged with a 3-bit channel select.
// Build macro TDM_FIXED_SLOT_EN swaps the round-robin search for a fixed rotating slot that may emit bubbles.
module tdm_mux_8ch #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  tdm_mux_8ch_if.slave bus
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        sel_q;
  logic [2:0]        gnt;
  logic              gnt_found;
  logic [DATA_W-1:0] gnt_word;
  logic              cap;
  logic              take;
  logic              drain;

`ifdef TDM_FIXED_SLOT_EN
  logic [2:0] slot;
`else
  logic [2:0] last;
  logic [2:0] idx;
`endif

  // Holding off capacity during reset keeps in_ready low and stops anything being accepted.
  assign cap   = !rst && ((state == EMPTY) || bus.out_ready);
  assign drain = (state == FULL) && bus.out_ready;
  assign take  = gnt_found && cap;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
`ifdef TDM_FIXED_SLOT_EN
    gnt       = slot;
    gnt_found = bus.in_valid[slot];
`else
    idx = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = 3'(last + 3'(i));
      if (!gnt_found && bus.in_valid[idx]) begin
        gnt       = idx;
        gnt_found = 1'b1;
      end
    end
`endif
  end

  assign gnt_word = bus.in_data[int'(gnt)*DATA_W +: DATA_W];

  always_comb begin
    bus.in_ready = '0;
    if (take) bus.in_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (take) state_nxt = FULL;
      FULL:    if (drain && !take) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      sel_q  <= '0;
`ifdef TDM_FIXED_SLOT_EN
      slot   <= '0;
`else
      last   <= 3'd7;
`endif
    end else begin
      state <= state_nxt;
      if (take) begin
        data_q <= gnt_word;
        sel_q  <= gnt;
      end
`ifdef TDM_FIXED_SLOT_EN
      // The slot rotates whenever the output could take a word, valid or not.
      if (cap) slot <= slot + 3'd1;
`else
      if (take) last <= gnt;
`endif
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_tdm_mux_8ch.sv
// Self-checking bench for tdm_mux_8ch: directed scenarios plus randomized valid/ready traffic against a behavioural model.
// The model tracks the output word, the last grant and the fixed slot, and it predicts in_ready on every cycle.
module tb_tdm_mux_8ch;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;

  tdm_mux_8ch_if #(.DATA_W(DATA_W)) bus ();
  tdm_mux_8ch #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] chan_data [8];

  bit          m_known = 1'b0;
  bit          m_valid = 1'b0;
  logic [7:0]  m_data  = '0;
  int          m_sel   = 0;
  int          m_last  = 7;
  int          m_slot  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Which channel the spec's arbitration rule would offer this cycle, or -1.
  function automatic int model_pick(input logic [7:0] v);
`ifdef TDM_FIXED_SLOT_EN
    return v[m_slot] ? m_slot : -1;
`else
    for (int k = 1; k <= 8; k++)
      if (v[(m_last + k) % 8]) return (m_last + k) % 8;
    return -1;
`endif
  endfunction

  // One clock cycle, entered and left on a falling edge.
  task automatic step(input logic r, input logic [7:0] v, input logic ordy, output int granted);
    logic [7:0] exp_rdy;
    bit         cap;
    int         p;
    if (m_known) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("out_data",  32'(bus.out_data),  32'(m_data));
      check("out_sel",   32'(bus.out_sel),   32'(m_sel));
    end
    rst           = r;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    for (int k = 0; k < 8; k++) bus.in_data[k*DATA_W +: DATA_W] = chan_data[k];
    #1;
    cap     = !m_valid || ordy;
    p       = model_pick(v);
    exp_rdy = '0;
    granted = -1;
    if (!r && cap && p >= 0) begin
      exp_rdy[p] = 1'b1;
      granted    = p;
    end
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_last  = 7;
      m_slot  = 0;
      m_known = 1'b1;
    end else begin
      if (granted >= 0) begin
        m_valid = 1'b1;
        m_data  = chan_data[granted];
        m_sel   = granted;
        m_last  = granted;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
      if (cap) m_slot = (m_slot + 1) % 8;
    end
    @(negedge clk);
  endtask

  initial begin
    int         g;
    logic [7:0] vreg;
    logic       ordy;
    logic       r;

    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) chan_data[k] = 8'h10 + 8'(k);
    @(negedge clk);

    // Reset held two cycles with every channel requesting: nothing accepted, output empty.
    step(1'b1, 8'hFF, 1'b1, g);
    step(1'b1, 8'hFF, 1'b1, g);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);

`ifndef TDM_FIXED_SLOT_EN
    // Full load: strict rotation 0..7 with one word per cycle.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'hFF, 1'b1, g);
      check("rr_sel",   32'(bus.out_sel),   32'(i % 8));
      check("rr_data",  32'(bus.out_data),  32'(8'h10 + 8'(i % 8)));
      check("rr_valid", 32'(bus.out_valid), 32'd1);
    end

    // Sparse channels 1 and 7: pointer wraps without bubbles.
    step(1'b1, 8'h00, 1'b1, g);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h82, 1'b1, g);
      check("sparse_sel", 32'(bus.out_sel), (i % 2 == 0) ? 32'd1 : 32'd7);
    end

    // Backpressure on channel 3 word A5, channel 4 waiting behind it.
    step(1'b1, 8'h00, 1'b1, g);
    chan_data[3] = 8'hA5;
    step(1'b0, 8'h08, 1'b0, g);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h10, 1'b0, g);
      check("bp_sel",   32'(bus.out_sel),  32'd3);
      check("bp_data",  32'(bus.out_data), 32'hA5);
      check("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    step(1'b0, 8'h10, 1'b1, g);
    check("bp_next_sel", 32'(bus.out_sel), 32'd4);

    // Reset during a stall discards the word; priority restarts at channel 0.
    step(1'b1, 8'hFF, 1'b0, g);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, 8'hFF, 1'b1, g);
    check("midrst_sel", 32'(bus.out_sel), 32'd0);
`else
    // Fixed slots with channels 0 and 2 valid: two words and six bubbles per frame.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h05, 1'b1, g);
      check("slot_valid", 32'(bus.out_valid), (i % 8 == 0 || i % 8 == 2) ? 32'd1 : 32'd0);
      if (i % 8 == 0) check("slot_sel0", 32'(bus.out_sel), 32'd0);
      if (i % 8 == 2) check("slot_sel2", 32'(bus.out_sel), 32'd2);
    end
    // Stall with a word held: the slot counter must freeze.
    for (int i = 0; i < 4; i++) step(1'b0, 8'h05, 1'b0, g);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h05, 1'b1, g);
`endif

    // Randomized traffic: a channel keeps its word until accepted, then may load a new one.
    for (int k = 0; k < 8; k++) chan_data[k] = 8'($urandom);
    vreg = '0;
    step(1'b1, vreg, 1'b1, g);
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (!vreg[k] && $urandom_range(0, 2) == 0) begin
          vreg[k]      = 1'b1;
          chan_data[k] = 8'($urandom);
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      r    = ($urandom_range(0, 199) == 0);
      step(r, vreg, ordy, g);
      if (g >= 0) vreg[g] = 1'b0;
    end
    step(1'b0, 8'h00, 1'b1, g);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_mux_8ch.md
Name: tdm_mux_8ch

Overview:
- Sequential 8-to-1 time-division multiplexer; transmit-side counterpart of the team's 1x8 demultiplexer tree.
- Gathers words from 8 independent valid/ready input channels and emits one stream.
- Each output word carries a 3-bit channel select, so a downstream 1x8 demux can route it back to output y0..y7.
- Round-robin arbitration with a single-entry registered output stage.

Parameters:
- DATA_W, 8, width of each channel word and of out_data.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset; sampled only on rising clk.
- in_data  input  8*DATA_W  channel words; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  input  8  per-channel word-present flags.
- in_ready  output  8  per-channel accept; at most one bit high per cycle (one-hot or zero).
- out_data  output  DATA_W  registered output word.
- out_sel  output  3  channel index of out_data; bit 2 MSB, matching the demux sel ordering.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - out_valid=0, out_data=0, out_sel=0, in_ready=0.
  - Round-robin pointer last=7, so channel 0 has first priority.
  - A transfer in flight is discarded; nothing is emitted after rst deasserts.
- Capacity: cap = !out_valid || out_ready (combinational).
- Grant:
  - Search in_valid starting at channel (last+1) mod 8 and wrapping upward.
  - The first valid channel g is granted.
  - in_ready[g] = cap; all other in_ready bits are 0.
  - in_ready is combinational from in_valid, last, out_valid and out_ready. No input-to-input combinational loop.
- Input transfer: occurs when in_valid[g] && in_ready[g]. On that clk edge:
  - out_data <= word of channel g.
  - out_sel <= g.
  - out_valid <= 1.
  - last <= g.
- Output transfer: occurs when out_valid && out_ready.
  - If no input transfer happens in the same cycle: out_valid <= 0; out_data and out_sel hold their last values.
  - Simultaneous output and input transfer: the register reloads with the new word and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Stall: while out_valid && !out_ready, out_data, out_sel and out_valid hold stable and every in_ready bit is 0.
- Latency: input transfer at edge N gives out_valid=1 with that word immediately after edge N (1 cycle).
- Fairness:
  - With all 8 channels valid continuously and out_ready=1, grants are 0,1,...,7,0,...
  - No channel waits more than 7 grants.
- No valid channel: last is unchanged and in_ready=0.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on input transfer.
  - FULL->EMPTY on output transfer without input transfer.
  - FULL->FULL on stall, or on output transfer with input transfer.
  - EMPTY->EMPTY when no input is valid.
  - Any state -> EMPTY on rst.
- Input assumption: in_data of a channel must stay stable while its in_valid=1 and it is not accepted. The block does not check this.

Optional Feature:
- Macro: TDM_FIXED_SLOT_EN.
- Defined (fixed-slot TDM mode):
  - A 3-bit slot counter (reset 0) replaces round-robin search.
  - The candidate channel is always g=slot.
  - The slot counter increments (7 wraps to 0) on every cycle where cap=1, whether or not in_valid[slot]=1.
  - If in_valid[slot]=0, that slot is lost (a bubble): out_valid goes 0 if the previous word drains.
  - The slot counter holds while cap=0.
  - The last register is unused.
- Undefined: work-conserving round-robin as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with in_valid=8'hFF → out_valid=0, in_ready=0 during reset. After release, first output is out_sel=0, one cycle after the first edge.
- Full load, round-robin: in_valid=8'hFF, channel k data=8'h10+k, out_ready=1 for 16 cycles → out_sel sequence 0..7,0..7, out_data 8'h10..8'h17 repeating, out_valid=1 every cycle after first.
- Sparse + wrap: in_valid=8'b1000_0010, last=7 after reset → grants 1,7,1,7. Pointer wraps 7→1 skipping idle channels, with no bubbles.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 with out_sel=3, data=8'hA5 → out_data/out_sel hold 8'hA5/3 and in_ready=0 throughout. On out_ready=1 the next channel (4 if valid) loads in the same cycle.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0. After release the next grant starts at channel 0, not last+1.
- TDM_FIXED_SLOT_EN: in_valid=8'b0000_0101, out_ready=1 → out_valid pattern 1,0,1,0,0,0,0,0 per 8-cycle frame with out_sel 0 then 2. Stalling out_ready freezes the slot counter.
